// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel format, feature-map writer states and
// the 17-to-16-bit saturation helper used by the post-processing stages.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int N      = 32;
  localparam int MAX_F  = 5;

  typedef logic signed [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } fmap_state_t;

  // Overflow shows up as the two top bits of the 17-bit sum disagreeing.
  function automatic pixel_t sat16(input logic signed [DATA_W:0] x);
    if (x[DATA_W] != x[DATA_W-1]) begin
      return x[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv_fmap_writer_if.sv
// Stream, configuration and feature-map bundle between the convolve engine,
// the feature-map writer and the next layer that reads the finished map.
interface conv_fmap_writer_if #(
  parameter int N = 32
);
  import cnn_pkg::pixel_t;

  logic        start;
  logic [15:0] img_size;
  logic [15:0] filter_size;
  pixel_t      bias;
  logic        relu_en;
  logic        in_valid;
  pixel_t      in_data;
  logic        in_ready;
  pixel_t      fmap [0:N*N-1];
  logic [15:0] out_size;
  logic [15:0] count;
  logic        done;
  logic        err;

  modport master (
    output start, img_size, filter_size, bias, relu_en, in_valid, in_data,
    input  in_ready, fmap, out_size, count, done, err
  );

  modport slave (
    input  start, img_size, filter_size, bias, relu_en, in_valid, in_data,
    output in_ready, fmap, out_size, count, done, err
  );

endinterface

// File: rtl/conv_fmap_writer_postproc.sv
// Combinational bias add, signed saturation and optional ReLU; shared by
// the convolution writer and the pooling stages.
module fmap_postproc
  import cnn_pkg::*;
(
  input  pixel_t data_i,
  input  pixel_t bias_i,
  input  logic   relu_en_i,
  output pixel_t result_o
);

  logic signed [DATA_W:0] sum;
  pixel_t                 sat;

  assign sum      = {data_i[DATA_W-1], data_i} + {bias_i[DATA_W-1], bias_i};
  assign sat      = sat16(sum);
  assign result_o = (relu_en_i && sat[DATA_W-1]) ? '0 : sat;

endmodule

// File: rtl/conv_fmap_writer.sv
// Feature-map writer: latches a frame configuration, post-processes each
// accepted sample and stores it row-major, pulsing done when the map is full.
module conv_fmap_writer #(
  parameter int N     = cnn_pkg::N,
  parameter int MAX_F = cnn_pkg::MAX_F
) (
  input logic               clk,
  input logic               reset_n,
  conv_fmap_writer_if.slave bus
);
  import cnn_pkg::pixel_t;
  import cnn_pkg::fmap_state_t;
  import cnn_pkg::IDLE;
  import cnn_pkg::COLLECT;
  import cnn_pkg::DONE;

  localparam int AW = $clog2(N*N);

  fmap_state_t state_q, state_d;
  logic [15:0] row_q, col_q, count_q, out_size_q;
  pixel_t      bias_q;
  logic        relu_q, err_q;
  pixel_t      fmap_q [0:N*N-1];

  logic        cfg_bad, accept, last_pos, ready, done;
  logic        start_idle;
  logic [AW-1:0] addr;
  pixel_t      result;

  // Filter must be a positive odd size that fits both the engine and the image.
  assign cfg_bad = (bus.filter_size == 16'd0) || !bus.filter_size[0] ||
                   (bus.filter_size > 16'(MAX_F)) || (bus.img_size > 16'(N)) ||
                   (bus.filter_size > bus.img_size);

  assign start_idle = (state_q == IDLE) && bus.start;
  assign accept     = bus.in_valid && ready;
  assign last_pos   = (row_q == out_size_q - 16'd1) && (col_q == out_size_q - 16'd1);
  assign addr       = AW'(row_q * out_size_q + col_q);

  fmap_postproc u_postproc (
    .data_i    (bus.in_data),
    .bias_i    (bias_q),
    .relu_en_i (relu_q),
    .result_o  (result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = cfg_bad ? DONE : COLLECT;
      COLLECT: if (accept && last_pos) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == COLLECT);
    done  = (state_q == DONE);
  end

  // A new frame overwrites only the positions it reaches; the rest of the map persists.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q      <= '0;
      col_q      <= '0;
      count_q    <= '0;
      out_size_q <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N*N; i++) fmap_q[i] <= '0;
    end else if (start_idle) begin
      out_size_q <= bus.img_size - ((bus.filter_size >> 1) << 1);
      bias_q     <= bus.bias;
      relu_q     <= bus.relu_en;
      err_q      <= cfg_bad;
      row_q      <= '0;
      col_q      <= '0;
      count_q    <= '0;
    end else if (accept) begin
      fmap_q[addr] <= result;
      count_q      <= count_q + 16'd1;
      if (col_q == out_size_q - 16'd1) begin
        col_q <= '0;
        row_q <= row_q + 16'd1;
      end else begin
        col_q <= col_q + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < N*N; i++) begin : g_fmap
    assign bus.fmap[i] = fmap_q[i];
  end

  assign bus.in_ready = ready;
  assign bus.done     = done;
  assign bus.err      = err_q;
  assign bus.count    = count_q;
  assign bus.out_size = out_size_q;

endmodule

// File: doc/conv_fmap_writer.md
# conv_fmap_writer

Sink side of the convolution stream. Accepts one convolved sample per handshake from the window/convolve engine and applies bias, saturation and optional ReLU. Writes each result row-major into an on-block output feature-map buffer. Signals completion once all `out_size × out_size` positions are filled, so the next layer can read the map.

## Interface
Parameters:
- `N`, 32: maximum input image side; the buffer holds `N*N` words.
- `MAX_F`, 5: maximum filter side.

Ports:
- `clk` in, 1: single clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: pulse that latches configuration and begins a frame.
- `img_size` in, 16: input image side.
- `filter_size` in, 16: filter side.
- `bias` in, signed 16: added to every sample.
- `relu_en` in, 1: clamp negative results to 0.
- `in_valid` in, 1: `in_data` is valid.
- `in_data` in, signed 16: convolved sample.
- `in_ready` out, 1: the block accepts a sample this cycle.
- `fmap` out, signed 16 `[0:N*N-1]`: output feature map, row-major, stride `out_size`.
- `out_size` out, 16: latched output side.
- `count` out, 16: samples written this frame.
- `done` out, 1: one-cycle completion pulse.
- `err` out, 1: sticky configuration error, cleared by the next `start`.

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE → COLLECT on `start`. This latches `img_size`, `filter_size`, `bias` and `relu_en`, computes `out_size = img_size − ((filter_size>>1)<<1)`, clears `row`, `col`, `count` and `err`.
- Config check on `start`. A config is invalid if:
  - `filter_size` is 0, even, or greater than `MAX_F`;
  - `img_size` is greater than `N`;
  - `filter_size` is greater than `img_size`.
- On an invalid config: `err`=1, go directly to DONE, no writes.
- COLLECT: `in_ready`=1. On `in_valid && in_ready`:
  - compute `sum = in_data + bias` in 17 bits;
  - saturate to [−32768, 32767];
  - if `relu_en` and the result is negative, the result is 0;
  - write the result to `fmap[row*out_size + col]`;
  - `count`++, `col`++;
  - when `col == out_size−1`: `col`=0, `row`++.
- COLLECT → DONE on the edge that accepts the sample at `row = col = out_size−1`.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE.
- `in_valid` outside COLLECT is ignored: `in_ready`=0, no write.
- Entries not written in a frame keep their previous contents. The buffer is not cleared on `start`.
- Indices `row` and `col` are 16-bit unsigned. The address is `row*out_size+col`, truncated to `log2(N*N)` bits; a valid config never exceeds `N*N−1`.

## Timing
- Reset (async, `reset_n`=0): state IDLE; `in_ready`=0, `done`=0, `err`=0, `count`=0, `out_size`=0; all `fmap` entries 0.
- Write latency: the sample accepted at edge k is visible on `fmap` and reflected in `count` after edge k.
- `done` rises on the edge after the last acceptance and falls one cycle later.
- `in_ready` rises the cycle after `start` is sampled in IDLE.
- Throughput: 1 sample/cycle, no bubbles.
- An invalid config gives `done`=1 and `err`=1 on the cycle after `start`.
- Reset mid-frame: immediate return to IDLE; the partial map is cleared to 0.
- `start` asserted on the same cycle as `done`: ignored, because the block is in DONE, not IDLE.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_W`=16, `N`=32, `MAX_F`=5;
  - typedef `pixel_t` (signed 16);
  - state enum `fmap_state_t`;
  - function `sat16` (17→16-bit saturation).
- One sub-module: `fmap_postproc`, combinational bias + saturate + ReLU. It is reused by pooling and other layers.
- The FSM, counters and buffer live in `conv_fmap_writer`.

## Test plan
- img 5, filter 3 (`out_size` 3), bias 0, ReLU off, stream samples 1..9 with `in_valid` held high → `fmap[0..8]` = 1..9; `count`=9; `done` pulses exactly one cycle, on the cycle after the 9th accept.
- Same config with `in_valid` toggled every other cycle → identical map; `done` is delayed by the gaps; no duplicate or missed writes.
- Saturation and ReLU:
  - bias 100, `in_data` 32700 → stored 32767;
  - bias −100, `in_data` −32700 → stored −32768;
  - with `relu_en`=1 → the second case is stored 0.
- Invalid configs, each giving `err`=1 and `done` on the cycle after `start`, `fmap` unchanged:
  - filter 4;
  - filter 7;
  - img 40;
  - filter 5 with img 3.
- Reset mid-frame: `reset_n` low after 4 of 9 samples → `in_ready`=0 and `fmap[0..3]`=0 immediately. After `reset_n` rises, a new `start` completes a full 9-sample frame.
- Corner config: img 1, filter 1 → `out_size` 1; a single sample with bias 5 and data 7 is stored as 12, followed by a `done` pulse. A `start` issued during COLLECT is ignored (`row`, `col` and `count` are not disturbed).
